// File: rtl/conf_reg_responder.sv
// CONF write-channel responder: writes land in a shadow bank, COMMIT copies shadow to active.
// Define CONF_LOCK_EN to add the LOCK register at address 14 that blocks shadow/commit writes.
module conf_reg_responder #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 14,
    parameter int NUM_REGS    = 14,
    parameter int BUSY_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_data,
    input  logic              c_valid,
    output logic              c_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              cfg_update,
    output logic              cfg_pending,
    output logic              wr_err
);
    localparam int CNT_W = (BUSY_CYCLES > 0) ? $clog2(BUSY_CYCLES + 1) : 1;
    localparam logic [ADDR_W-1:0] COMMIT_ADDR = ADDR_W'(15);
    localparam logic [CNT_W-1:0]  BUSY_LOAD   = CNT_W'(BUSY_CYCLES);

    typedef enum logic [1:0] {INIT, IDLE, BUSY, COMMIT} state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  busy_cnt;
    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [DATA_W-1:0] active [NUM_REGS];
    logic              commit_sel;
    logic              accept, is_reg, is_commit, is_lock, locked;
    logic              do_reg_wr, do_commit, do_err;
    logic [DATA_W-1:0] rd_next;

`ifdef CONF_LOCK_EN
    localparam logic [ADDR_W-1:0] LOCK_ADDR = ADDR_W'(14);
    logic lock_q;

    // The lock register itself is always writable so a locked bank can be released.
    always_ff @(posedge clk) begin
        if (rst)
            lock_q <= 1'b0;
        else if (accept && is_lock)
            lock_q <= c_data[0];
    end

    assign locked  = lock_q;
    assign is_lock = (c_addr == LOCK_ADDR);
`else
    assign locked  = 1'b0;
    assign is_lock = 1'b0;
`endif

    always_comb begin
        accept    = c_valid && c_ready;
        is_reg    = (c_addr < ADDR_W'(NUM_REGS));
        is_commit = (c_addr == COMMIT_ADDR);
        do_reg_wr = accept && is_reg && !locked;
        do_commit = accept && is_commit && !locked;
        do_err    = accept && !do_reg_wr && !do_commit && !is_lock;
    end

    always_comb begin
        next_state = state;
        case (state)
            INIT:   next_state = IDLE;
            IDLE: begin
                if (do_commit)
                    next_state = COMMIT;
                else if (accept && BUSY_CYCLES > 0)
                    next_state = BUSY;
            end
            BUSY: begin
                if (busy_cnt <= CNT_W'(1))
                    next_state = IDLE;
            end
            COMMIT: next_state = IDLE;
            default: next_state = INIT;
        endcase
    end

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i))
                rd_next = active[i];
        end
`ifdef CONF_LOCK_EN
        if (rd_addr == LOCK_ADDR)
            rd_next = DATA_W'(lock_q);
`endif
    end

    // c_ready is registered from the next state so it is high exactly while in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            c_ready     <= 1'b0;
            busy_cnt    <= '0;
            commit_sel  <= 1'b0;
            rd_data     <= '0;
            cfg_update  <= 1'b0;
            cfg_pending <= 1'b0;
            wr_err      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            state      <= next_state;
            c_ready    <= (next_state == IDLE);
            cfg_update <= 1'b0;
            wr_err     <= do_err;
            rd_data    <= rd_next;

            if (accept)
                busy_cnt <= BUSY_LOAD;
            else if (state == BUSY && busy_cnt != '0)
                busy_cnt <= busy_cnt - CNT_W'(1);

            if (do_commit)
                commit_sel <= c_data[0];

            if (do_reg_wr) begin
                cfg_pending <= 1'b1;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (c_addr == ADDR_W'(i))
                        shadow[i] <= c_data;
                end
            end

            // Commit publishes shadow; discard rolls shadow back to the active values.
            if (state == COMMIT) begin
                cfg_pending <= 1'b0;
                if (commit_sel) begin
                    cfg_update <= 1'b1;
                    for (int i = 0; i < NUM_REGS; i++)
                        active[i] <= shadow[i];
                end else begin
                    for (int i = 0; i < NUM_REGS; i++)
                        shadow[i] <= active[i];
                end
            end
        end
    end

endmodule
